// File: rtl/nibble_reader_if.sv
// Link bundle for nibble_reader: parallel capture request and word, one-bit
// valid/ready serial stream, and status flags.
interface nibble_reader_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic [WIDTH-1:0] d;
   logic             sout_ready;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output en, d, sout_ready,
      input  q, sout, sout_valid, busy, done
   );

   modport slave (
      input  en, d, sout_ready,
      output q, sout, sout_valid, busy, done
   );
endinterface

// File: rtl/nibble_reader.sv
// Parallel-in / serial-out reader: snapshots d on en while idle, then shifts
// the word out MSB-first over a valid/ready link and pulses done at the end.
module nibble_reader #(
   parameter int unsigned WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   nibble_reader_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] sh_r;
   logic [WIDTH-1:0] sh_nxt;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_nxt;
   logic             valid_d;
   logic             busy_d;
   logic             done_d;

   // State and datapath registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q_r   <= WIDTH'(1);
         sh_r  <= '0;
         cnt_r <= '0;
      end else begin
         state <= state_nxt;
         q_r   <= q_nxt;
         sh_r  <= sh_nxt;
         cnt_r <= cnt_nxt;
      end
   end

   // Next-state, datapath update and status decode.
   always_comb begin
      state_nxt = state;
      q_nxt     = q_r;
      sh_nxt    = sh_r;
      cnt_nxt   = cnt_r;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.en) begin
               q_nxt     = bus.d;
               sh_nxt    = bus.d;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end

         SHIFT: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            if (bus.sout_ready) begin
               sh_nxt = {sh_r[WIDTH-2:0], 1'b0};
               // Clear on the last bit so the count never passes WIDTH-1.
               if (cnt_r == CW'(WIDTH - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt_r + CW'(1);
               end
            end
         end

         DONE: begin
            busy_d    = 1'b1;
            done_d    = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.q          = q_r;
   assign bus.sout       = sh_r[WIDTH-1];
   assign bus.sout_valid = valid_d;
   assign bus.busy       = busy_d;
   assign bus.done       = done_d;
endmodule

// File: tb/tb_nibble_reader.sv
// Self-checking bench for nibble_reader: table of transfers with stall patterns
// plus hand-written reset, abort and back-to-back sequences.
module tb_nibble_reader;
   localparam int unsigned WIDTH = 4;

   logic clk;
   logic rst;
   logic mon_en;
   int   n_chk;
   int   n_fail;
   int   done_cnt;
   logic sb[$];

   nibble_reader_if #(.WIDTH(WIDTH)) bus ();

   nibble_reader #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  d;
      logic [15:0] stall;
      logic        poke;
      int          exp_done;
   } xfer_t;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   task automatic push_word(input logic [3:0] dv);
      for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(dv[i]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every offered bit must match the queue head; pop on handshake.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (bus.sout_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(bus.sout), 32'hBAD);
            end else begin
               chk("sout_bit", 32'(bus.sout), 32'(sb[0]));
               if (bus.sout_ready) void'(sb.pop_front());
            end
         end else begin
            chk("sout_idle_zero", 32'(bus.sout), 32'd0);
         end
         if (bus.done === 1'b1) done_cnt++;
      end
   end

   // One transfer; caller leaves the DUT idle just after a rising edge.
   task automatic run_xfer(input xfer_t x);
      logic [3:0] rd;
      rd = 4'($urandom);
      bus.d          = x.d;
      bus.en         = 1'b1;
      bus.sout_ready = ~x.stall[0];
      push_word(x.d);
      tick();
      for (int c = 1; c <= 12; c++) begin
         bus.sout_ready = ~x.stall[c-1];
         bus.en         = (x.poke && c == 2);
         bus.d          = (x.poke && c == 2) ? 4'hF : rd;
         chk("sout_valid", 32'(bus.sout_valid), 32'(c < x.exp_done));
         chk("busy",       32'(bus.busy),       32'(c <= x.exp_done));
         chk("done",       32'(bus.done),       32'(c == x.exp_done));
         chk("q_hold",     32'(bus.q),          32'(x.d));
         tick();
      end
   endtask

   initial begin
      xfer_t tbl[6];
      int    dc0;
      int    ddone;

      n_chk    = 0;
      n_fail   = 0;
      done_cnt = 0;
      mon_en   = 1'b0;

      tbl[0] = '{d: 4'b1011, stall: 16'h0000, poke: 1'b0, exp_done: 5};
      tbl[1] = '{d: 4'b0110, stall: 16'h0002, poke: 1'b0, exp_done: 6};
      tbl[2] = '{d: 4'b1011, stall: 16'h0000, poke: 1'b1, exp_done: 5};
      tbl[3] = '{d: 4'b0000, stall: 16'h0000, poke: 1'b0, exp_done: 5};
      tbl[4] = '{d: 4'b1111, stall: 16'h0005, poke: 1'b0, exp_done: 7};
      tbl[5] = '{d: 4'b1000, stall: 16'h0038, poke: 1'b1, exp_done: 8};

      // Reset with random request traffic.
      rst            = 1'b1;
      bus.en         = 1'($urandom);
      bus.d          = 4'($urandom);
      bus.sout_ready = 1'($urandom);
      tick();
      bus.en = 1'($urandom);
      bus.d  = 4'($urandom);
      tick();
      chk("rst_q",          32'(bus.q),          32'h1);
      chk("rst_sout",       32'(bus.sout),       32'h0);
      chk("rst_sout_valid", 32'(bus.sout_valid), 32'h0);
      chk("rst_busy",       32'(bus.busy),       32'h0);
      chk("rst_done",       32'(bus.done),       32'h0);
      rst    = 1'b0;
      bus.en = 1'b0;
      mon_en = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         dc0 = done_cnt;
         run_xfer(tbl[i]);
         chk("xfer_done_pulses", 32'(done_cnt - dc0), 32'd1);
         chk("xfer_sb_drained",  32'(sb.size()),      32'd0);
      end

      // Abort after two accepted bits.
      dc0            = done_cnt;
      bus.d          = 4'b1011;
      bus.en         = 1'b1;
      bus.sout_ready = 1'b1;
      push_word(4'b1011);
      tick();
      bus.en = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      sb.delete();
      chk("abort_q",          32'(bus.q),          32'h1);
      chk("abort_sout",       32'(bus.sout),       32'h0);
      chk("abort_sout_valid", 32'(bus.sout_valid), 32'h0);
      chk("abort_busy",       32'(bus.busy),       32'h0);
      chk("abort_done",       32'(bus.done),       32'h0);
      rst = 1'b0;
      repeat (4) tick();
      chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
      run_xfer('{d: 4'b0101, stall: 16'h0000, poke: 1'b0, exp_done: 5});
      chk("abort_then_done", 32'(done_cnt - dc0), 32'd1);
      chk("abort_sb_drained", 32'(sb.size()), 32'd0);

      // Back-to-back with en held high.
      dc0            = done_cnt;
      ddone          = 0;
      bus.d          = 4'b0110;
      bus.en         = 1'b1;
      bus.sout_ready = 1'b1;
      push_word(4'b0110);
      push_word(4'b1001);
      tick();
      bus.d = 4'b1001;
      for (int c = 1; c <= 12; c++) begin
         if (c == 7) bus.en = 1'b0;
         chk("b2b_valid", 32'(bus.sout_valid), 32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
         chk("b2b_done",  32'(bus.done),       32'(c == 5 || c == 11));
         if (c <= 6) chk("b2b_q_first",  32'(bus.q), 32'h6);
         else        chk("b2b_q_second", 32'(bus.q), 32'h9);
         if (bus.done === 1'b1) ddone++;
         tick();
      end
      chk("b2b_done_total", 32'(ddone), 32'd2);
      chk("b2b_done_mon",   32'(done_cnt - dc0), 32'd2);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
